// File: rtl/interval_timer.sv
// interval_timer: a programmable seconds timer. It holds three 4-bit interval
// registers (base, ext, yellow). A prescaler turns clock cycles into
// one-second ticks, and a remaining counter counts the selected interval
// down. exp pulses for one cycle when the running interval ends.
// Optional build macro INTERVAL_TIMER_REMAIN_OUT_EN: when defined, the
// remaining counter is exported on the 'remain' output port.
module interval_timer #(
   parameter int CLK_PER_SEC = 1000,
   parameter int BASE_DEF    = 6,
   parameter int EXT_DEF     = 3,
   parameter int YEL_DEF     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       st_time,
   input  logic [1:0] intervel,
   input  logic       prog_sync,
   input  logic [1:0] time_sel,
   input  logic [3:0] time_value,
`ifdef INTERVAL_TIMER_REMAIN_OUT_EN
   output logic [3:0] remain,
`endif
   output logic       exp
);

   localparam int            PW  = $clog2(CLK_PER_SEC);
   localparam logic [PW-1:0] TOP = PW'(CLK_PER_SEC - 1);

   logic [PW-1:0] prescaler;
   logic [3:0]    remaining;
   logic [3:0]    base, ext, yellow;
   logic [3:0]    sel_val, load_val;
   logic          load, tick;

   // Choose the reload value. A program strobe always restarts on base and
   // reads the register contents from before this cycle's write. A stored 0
   // is timed as one second.
   always_comb begin
      sel_val = base;
      if (!prog_sync) begin
         case (intervel)
            2'b01:   sel_val = ext;
            2'b10:   sel_val = yellow;
            default: sel_val = base;
         endcase
      end
      load_val = (sel_val == 4'd0) ? 4'd1 : sel_val;
      load     = prog_sync | ~st_time;
      tick     = (prescaler == TOP);
   end

   // Interval registers. A write only affects the next load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base   <= 4'(BASE_DEF);
         ext    <= 4'(EXT_DEF);
         yellow <= 4'(YEL_DEF);
      end else if (prog_sync) begin
         case (time_sel)
            2'b00:   base   <= time_value;
            2'b01:   ext    <= time_value;
            2'b10:   yellow <= time_value;
            default: ;
         endcase
      end
   end

   // Prescaler, countdown and expiry pulse. A load overrides everything,
   // including an expiry that would otherwise land in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prescaler <= '0;
         remaining <= 4'(BASE_DEF);
         exp       <= 1'b0;
      end else if (load) begin
         prescaler <= '0;
         remaining <= load_val;
         exp       <= 1'b0;
      end else begin
         prescaler <= tick ? '0 : prescaler + PW'(1);
         if (tick && remaining != 4'd0)
            remaining <= remaining - 4'd1;
         exp <= tick && (remaining == 4'd1);
      end
   end

`ifdef INTERVAL_TIMER_REMAIN_OUT_EN
   assign remain = remaining;
`endif

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboarded bench for interval_timer (CLK_PER_SEC=4). The reference model
// tracks the absolute clock edge at which exp is due and pushes one expected
// exp bit per edge; a separate monitor pops and compares after each edge.
module tb_interval_timer;
   localparam int CPS = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       st_time = 1'b1;
   logic [1:0] intervel = 2'b00;
   logic       prog_sync = 1'b0;
   logic [1:0] time_sel = 2'b11;
   logic [3:0] time_value = 4'd0;
   logic       exp;
`ifdef INTERVAL_TIMER_REMAIN_OUT_EN
   logic [3:0] remain;
`endif

   interval_timer #(.CLK_PER_SEC(CPS), .BASE_DEF(6), .EXT_DEF(3), .YEL_DEF(2)) dut (
      .clk(clk), .reset(reset), .st_time(st_time), .intervel(intervel),
      .prog_sync(prog_sync), .time_sel(time_sel), .time_value(time_value),
`ifdef INTERVAL_TIMER_REMAIN_OUT_EN
      .remain(remain),
`endif
      .exp(exp)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     failures = 0;
   bit     exp_q[$];
   longint edge_n = 0;     // index of the last modelled rising edge
   longint deadline = 0;   // edge at which exp is due, -1 if none
   int     m_reg[3];       // base, ext, yellow
   int     n_exp = 0;

   function automatic int nz(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   // Drive inputs for the next edge and push the expected exp after it.
   task automatic step(input logic st, input logic [1:0] iv, input logic ps,
                       input logic [1:0] ts, input logic [3:0] tv);
      bit e;
      @(negedge clk);
      st_time = st; intervel = iv; prog_sync = ps; time_sel = ts; time_value = tv;
      edge_n++;
      e = 1'b0;
      if (ps) begin
         deadline = edge_n + CPS * nz(m_reg[0]);
         if (ts != 2'b11) m_reg[ts] = int'(tv);
      end else if (!st) begin
         deadline = edge_n + CPS * nz(m_reg[(iv == 2'b11) ? 0 : iv]);
      end else if (deadline == edge_n) begin
         e = 1'b1;
         deadline = -1;
      end
      if (e) n_exp++;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 2'b11, 4'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      st_time = 1'b1; prog_sync = 1'b0;
      #1;
      checks++;
      if (exp !== 1'b0) begin
         failures++;
         $display("FAIL reset_exp got=%0b want=0", exp);
      end
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      m_reg[0] = 6; m_reg[1] = 3; m_reg[2] = 2;
      deadline = edge_n + CPS * 6;
   endtask

   // Monitor: compare exp after every modelled edge.
   initial begin
      bit e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (exp !== e) begin
               failures++;
               $display("FAIL exp edge=%0d got=%0b want=%0b", edge_n, exp, e);
            end
         end
      end
   end

   initial begin
      int r;
      int n0;
      m_reg[0] = 6; m_reg[1] = 3; m_reg[2] = 2;
      deadline = CPS * 6;
      #1;
      checks++;
      if (exp !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got=%0b want=0", exp);
      end
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;

      // Free run from reset: single exp at edge 24, then silence.
      run(40);
      checks++;
      if (n_exp != 1) begin
         failures++;
         $display("FAIL first_exp_count got=%0d want=1", n_exp);
      end

      // Yellow and the 11 alias of base.
      step(1'b0, 2'b10, 1'b0, 2'b11, 4'd0); run(12);
      step(1'b0, 2'b11, 1'b0, 2'b11, 4'd0); run(30);

      // Program ext=5: restart uses old base, then ext load gives 20 clocks.
      step(1'b1, 2'b10, 1'b1, 2'b01, 4'd5); run(30);
      step(1'b0, 2'b01, 1'b0, 2'b11, 4'd0); run(24);

      // Yellow=0 is timed as one second.
      step(1'b1, 2'b00, 1'b1, 2'b10, 4'd0); run(30);
      step(1'b0, 2'b10, 1'b0, 2'b11, 4'd0); run(8);

      // Prog coincident with st_time low: prog wins (base restart).
      step(1'b0, 2'b10, 1'b1, 2'b11, 4'd0); run(30);

      // Load on the exp-due edge cancels exp, full interval follows.
      step(1'b0, 2'b00, 1'b0, 2'b11, 4'd0);
      for (int i = 0; i < 100 && edge_n + 1 != deadline; i++) run(1);
      n0 = n_exp;
      step(1'b0, 2'b00, 1'b0, 2'b11, 4'd0);
      run(30);
      checks++;
      if (n_exp != n0 + 1) begin
         failures++;
         $display("FAIL cancel_reload got=%0d want=%0d", n_exp - n0, 1);
      end

      // Base=9, reset mid-interval: back to defaults.
      step(1'b1, 2'b00, 1'b1, 2'b00, 4'd9); run(10);
      do_reset();
      run(30);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 999);
         if (r == 0) do_reset();
         else if (r < 15)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1,
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
         else if (r < 35)
            step(1'b0, 2'($urandom_range(0, 3)), 1'b0,
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
         else
            step(1'b1, 2'($urandom_range(0, 3)), 1'b0,
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      end

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
